// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
// Issues single-outstanding word reads over a req/ack handshake, buffers the
// returned words in a small prefetch FIFO, presents NOP bubbles when empty,
// holds its output on stall and redirects on a taken jump.
module fetch_unit #(
    parameter int unsigned          XLEN         = 32,
    parameter logic [XLEN-1:0]      RESET_VECTOR = '0,
    parameter int unsigned          DEPTH        = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            je,
    input  logic [XLEN-1:0] ja,
    output logic [29:0]     instr,
    output logic [XLEN-1:0] curr_pc,
    output logic [XLEN-1:0] inc_pc,
    output logic            imem_re,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_data
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [29:0] NOP_INSTR = 30'h0000004;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] fifo_pc    [DEPTH];
    logic [29:0]     fifo_instr [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic            pending;
    logic            drop;

    logic            empty;
    logic            ack_ok;
    logic            redirect;
    logic            issue;
    logic            push;
    logic            pop;

    // Handshake qualification, request generation and output selection.
    // The outstanding request keeps its own address register so imem_addr
    // stays stable while a redirect has already moved fetch_pc.
    always_comb begin
        empty     = (count == '0);
        ack_ok    = pending & imem_ack;
        redirect  = je & ~stall;
        imem_re   = ~rst & (pending | (count < CW'(DEPTH)));
        issue     = imem_re & ~pending;
        push      = ack_ok & ~drop & ~redirect;
        pop       = ~empty & ~stall;
        imem_addr = pending ? req_addr : fetch_pc;
        if (empty) begin
            instr   = NOP_INSTR;
            curr_pc = fetch_pc;
        end else begin
            instr   = fifo_instr[rd_ptr];
            curr_pc = fifo_pc[rd_ptr];
        end
        inc_pc = curr_pc + XLEN'(4);
    end

    // Control state: fetch PC, outstanding request, drop flag and FIFO pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_VECTOR;
            req_addr <= RESET_VECTOR;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            pending  <= 1'b0;
            drop     <= 1'b0;
        end else begin
            if (ack_ok) begin
                pending <= 1'b0;
            end else if (issue) begin
                pending  <= 1'b1;
                req_addr <= fetch_pc;
            end

            if (redirect) begin
                // Anything still in flight after this edge belongs to the old path,
                // including a request that is being issued in this very cycle.
                fetch_pc <= {ja[XLEN-1:2], 2'b00};
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                drop     <= (pending & ~imem_ack) | issue;
            end else begin
                if (ack_ok) begin
                    drop <= 1'b0;
                end
                if (push) begin
                    fetch_pc <= fetch_pc + XLEN'(4);
                    wr_ptr   <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // FIFO storage: {pc, instr[31:2]} written on accepted acks.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]    <= fetch_pc;
            fifo_instr[wr_ptr] <= imem_data[31:2];
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit against a behavioural
// instruction memory with programmable ack latency.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        je = 1'b0;
    logic [31:0] ja = '0;
    logic [29:0] instr;
    logic [31:0] curr_pc;
    logic [31:0] inc_pc;
    logic        imem_re;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_data = '0;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // memory model state
    int unsigned lat = 0;
    logic        stray_en = 1'b0;
    logic        s_re = 1'b0;
    logic        s_rst = 1'b1;
    logic        s_stray = 1'b0;
    logic [31:0] s_addr = '0;
    logic [31:0] raddr = '0;
    logic        busy = 1'b0;
    int unsigned cnt = 0;
    logic [31:0] log_q [$];

    fetch_unit #(
        .XLEN         (32),
        .RESET_VECTOR (32'h0),
        .DEPTH        (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .je        (je),
        .ja        (ja),
        .instr     (instr),
        .curr_pc   (curr_pc),
        .inc_pc    (inc_pc),
        .imem_re   (imem_re),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_data (imem_data)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0) ? 32'h00500093 : (a ^ 32'hC0DE0003);
    endfunction

    function automatic logic [29:0] exp_instr(input logic [31:0] a);
        logic [31:0] w;
        w = mem_word(a);
        return w[31:2];
    endfunction

    // sample DUT request lines away from the active edge
    initial forever begin
        @(negedge clk);
        s_re    = imem_re;
        s_addr  = imem_addr;
        s_rst   = rst;
        s_stray = stray_en;
    end

    // responder: captures a request, acks after lat cycles for one cycle
    initial forever begin
        @(posedge clk);
        #1;
        if (s_rst) begin
            busy      = 1'b0;
            imem_ack  = s_stray;
            imem_data = 32'hFFFF_FFFF;
        end else if (imem_ack) begin
            imem_ack = 1'b0;
            busy     = 1'b0;
        end else begin
            if (!busy && s_re) begin
                busy  = 1'b1;
                cnt   = lat;
                raddr = s_addr;
                log_q.push_back(s_addr);
            end else if (busy && s_re) begin
                check("addr_hold", s_addr, raddr);
            end
            if (busy) begin
                if (cnt == 0) begin
                    imem_ack  = 1'b1;
                    imem_data = mem_word(raddr);
                end else begin
                    cnt--;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int unsigned l, input logic st);
        rst   = 1'b1;
        stall = st;
        je    = 1'b0;
        lat   = l;
        step();
        step();
        log_q.delete();
        rst = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input logic [31:0] pc);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (curr_pc == pc && instr == exp_instr(pc)) found = 1'b1;
        end
        check(tag, found, 1);
    endtask

    task automatic wait_addr(input string tag, input logic [31:0] a);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (imem_re && imem_addr == a) found = 1'b1;
        end
        check(tag, found, 1);
    endtask

    initial begin
        // ---- reset and 1-cycle-ack streaming
        lat = 0;
        step();
        @(negedge clk);
        check("rst_re", imem_re, 0);
        check("rst_instr", instr, 30'h4);
        check("rst_pc", curr_pc, 32'h0);
        check("rst_inc", inc_pc, 32'h4);
        step();
        log_q.delete();
        rst = 1'b0;
        @(negedge clk);
        check("c0_re", imem_re, 1);
        check("c0_addr", imem_addr, 32'h0);
        step(); @(negedge clk);
        check("c1_bubble", instr, 30'h4);
        check("c1_pc", curr_pc, 32'h0);
        step(); @(negedge clk);
        check("c2_instr", instr, 30'h0014_0024);
        check("c2_pc", curr_pc, 32'h0);
        check("c2_inc", inc_pc, 32'h4);
        check("c2_addr", imem_addr, 32'h4);
        step(); @(negedge clk);
        check("c3_bubble", instr, 30'h4);
        check("c3_pc", curr_pc, 32'h4);
        step(); @(negedge clk);
        check("c4_instr", instr, 30'h3037_8001);
        check("c4_pc", curr_pc, 32'h4);
        check("c4_inc", inc_pc, 32'h8);
        check("c4_addr", imem_addr, 32'h8);

        // ---- 3-cycle ack latency: bubbles, single request
        do_reset(3, 1'b0);
        for (int c = 0; c < 5; c++) begin
            if (c != 0) step();
            @(negedge clk);
            check("lat_bubble", instr, 30'h4);
            check("lat_pc", curr_pc, 32'h0);
            check("lat_re", imem_re, 1);
            check("lat_addr", imem_addr, 32'h0);
        end
        step(); @(negedge clk);
        check("lat_instr", instr, 30'h0014_0024);
        check("lat_nreq", log_q.size(), 1);

        // ---- stall with FIFO filling
        do_reset(0, 1'b1);
        step(); step();
        for (int c = 2; c < 6; c++) begin
            @(negedge clk);
            check("stall_instr", instr, 30'h0014_0024);
            check("stall_pc", curr_pc, 32'h0);
            if (c >= 4) check("stall_full_re", imem_re, 0);
            step();
        end
        stall = 1'b0;
        @(negedge clk);
        check("unstall_pc", curr_pc, 32'h0);
        step(); @(negedge clk);
        check("unstall_pc2", curr_pc, 32'h4);
        check("unstall_instr2", instr, exp_instr(32'h4));
        check("unstall_addr", imem_addr, 32'h8);

        // ---- redirect while request to 0x8 pending
        do_reset(3, 1'b0);
        wait_addr("redir_see8", 32'h8);
        step();
        je = 1'b1; ja = 32'h103;
        step();
        je = 1'b0;
        @(negedge clk);
        check("redir_bubble", instr, 30'h4);
        check("redir_pc", curr_pc, 32'h100);
        check("redir_inc", inc_pc, 32'h104);
        check("redir_hold_addr", imem_addr, 32'h8);
        wait_valid("redir_valid", 32'h100);
        check("redir_log_last", log_q[log_q.size()-1], 32'h100);
        check("redir_log_prev", log_q[log_q.size()-2], 32'h8);
        check("redir_next_addr", imem_addr, 32'h104);

        // ---- je during stall is ignored
        do_reset(0, 1'b1);
        step(); step(); step(); step();
        je = 1'b1; ja = 32'h200;
        step();
        je = 1'b0;
        @(negedge clk);
        check("jstall_pc", curr_pc, 32'h0);
        check("jstall_instr", instr, 30'h0014_0024);
        check("jstall_re", imem_re, 0);
        step();
        stall = 1'b0;
        @(negedge clk);
        check("jstall_pc_b", curr_pc, 32'h0);
        step(); @(negedge clk);
        check("jstall_pc_c", curr_pc, 32'h4);

        // ---- wrap at top of address space (redirect during an issue)
        do_reset(0, 1'b0);
        je = 1'b1; ja = 32'hFFFF_FFFC;
        step();
        je = 1'b0;
        @(negedge clk);
        check("wrap_pc", curr_pc, 32'hFFFF_FFFC);
        check("wrap_bubble", instr, 30'h4);
        check("wrap_inc_bubble", inc_pc, 32'h0);
        wait_valid("wrap_valid", 32'hFFFF_FFFC);
        check("wrap_inc", inc_pc, 32'h0);
        check("wrap_re", imem_re, 1);
        check("wrap_addr", imem_addr, 32'h0);
        wait_valid("wrap_next", 32'h0);

        // ---- reset mid-request with stray ack afterwards
        do_reset(3, 1'b0);
        step(); step();
        stray_en = 1'b1;
        rst = 1'b1;
        step();
        @(negedge clk);
        check("mrst_re", imem_re, 0);
        step();
        rst = 1'b0;
        stray_en = 1'b0;
        log_q.delete();
        @(negedge clk);
        check("mrst_bubble", instr, 30'h4);
        check("mrst_pc", curr_pc, 32'h0);
        check("mrst_addr", imem_addr, 32'h0);
        step(); @(negedge clk);
        check("mrst_stray", instr, 30'h4);
        wait_valid("mrst_valid", 32'h0);
        check("mrst_nreq", log_q.size(), 1);
        check("mrst_req0", log_q[0], 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1);
    end

endmodule
